// File: rtl/byte_unstriping_pkg.sv
// Shared defaults and lane encodings for the two-lane byte unstriper.
package byte_unstriping_pkg;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH);

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;
endpackage

// File: rtl/byte_unstriping_lane.sv
// Per-lane skew FIFO: power-of-two depth, naturally wrapping pointers, drops on overflow.
module lane_fifo
  import byte_unstriping_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // A pop frees the slot this same edge, so a full FIFO can still accept a push.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    overflow = push & full & ~do_pop;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    dout     = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end
endmodule

// File: rtl/byte_unstriping.sv
// Re-interleaves two striped lanes into one ordered stream, lane 0 first.
// Optional sticky overflow reporting (err_overflow/err_lane) under `UNSTRIPE_ERR_EN.
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] lane_0,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] lane_1,
  input  logic              valid_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_full_0,
  output logic              fifo_full_1
`ifdef UNSTRIPE_ERR_EN
  ,
  output logic              err_overflow,
  output logic              err_lane
`endif
);
  logic [DATA_W-1:0] dout0, dout1;
  logic              empty0, empty1;
  logic              full0, full1;
  logic              ovf0, ovf1;
  logic              pop0, pop1;

  logic              sel_q, sel_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;

  lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk      (clk),
    .reset    (reset),
    .push     (valid_0),
    .din      (lane_0),
    .pop      (pop0),
    .dout     (dout0),
    .empty    (empty0),
    .full     (full0),
    .overflow (ovf0)
  );

  lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk      (clk),
    .reset    (reset),
    .push     (valid_1),
    .din      (lane_1),
    .pop      (pop1),
    .dout     (dout1),
    .empty    (empty1),
    .full     (full1),
    .overflow (ovf1)
  );

  // Only the selected lane may emit; the other lane waits even when it has data.
  always_comb begin
    sel_d       = sel_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    pop0        = 1'b0;
    pop1        = 1'b0;
    if (sel_q == LANE0) begin
      if (!empty0) begin
        pop0        = 1'b1;
        data_out_d  = dout0;
        valid_out_d = 1'b1;
        sel_d       = LANE1;
      end
    end else begin
      if (!empty1) begin
        pop1        = 1'b1;
        data_out_d  = dout1;
        valid_out_d = 1'b1;
        sel_d       = LANE0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q       <= LANE0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign fifo_full_0 = full0;
  assign fifo_full_1 = full1;

`ifdef UNSTRIPE_ERR_EN
  logic err_overflow_q, err_overflow_d;
  logic err_lane_q, err_lane_d;

  // Lane of the first overflow only; lane 0 wins a simultaneous first overflow.
  always_comb begin
    err_overflow_d = err_overflow_q | ovf0 | ovf1;
    err_lane_d     = err_lane_q;
    if (!err_overflow_q && (ovf0 || ovf1)) begin
      err_lane_d = ovf0 ? LANE0 : LANE1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_overflow_q <= 1'b0;
      err_lane_q     <= LANE0;
    end else begin
      err_overflow_q <= err_overflow_d;
      err_lane_q     <= err_lane_d;
    end
  end

  assign err_overflow = err_overflow_q;
  assign err_lane     = err_lane_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf0 | ovf1;
`endif
endmodule

// File: tb/tb_byte_unstriping.sv
// Directed table-driven bench for byte_unstriping plus hand-written reset sequences.
module tb_byte_unstriping;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lane_0, lane_1;
  logic        valid_0, valid_1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        fifo_full_0, fifo_full_1;
`ifdef UNSTRIPE_ERR_EN
  logic        err_overflow, err_lane;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v0;
    logic [31:0] l0;
    logic        v1;
    logic [31:0] l1;
    logic        evo;
    logic [31:0] edo;
    logic        ef0;
    logic        ef1;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  byte_unstriping dut (
    .clk         (clk),
    .reset       (reset),
    .lane_0      (lane_0),
    .valid_0     (valid_0),
    .lane_1      (lane_1),
    .valid_1     (valid_1),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .fifo_full_0 (fifo_full_0),
    .fifo_full_1 (fifo_full_1)
`ifdef UNSTRIPE_ERR_EN
    ,
    .err_overflow(err_overflow),
    .err_lane    (err_lane)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic row(input logic v0, input logic [31:0] l0, input logic v1, input logic [31:0] l1,
                     input logic evo, input logic [31:0] edo, input logic ef0, input logic ef1,
                     input logic eerr);
    vecs.push_back('{v0: v0, l0: l0, v1: v1, l1: l1, evo: evo, edo: edo,
                     ef0: ef0, ef1: ef1, eerr: eerr});
  endtask

  task automatic step(input logic v0, input logic [31:0] l0, input logic v1, input logic [31:0] l1);
    valid_0 = v0; lane_0 = l0;
    valid_1 = v1; lane_1 = l1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic evo, input logic [31:0] edo);
    check({tag, " valid_out"}, {31'd0, valid_out}, {31'd0, evo});
    check({tag, " data_out"}, data_out, edo);
  endtask

  initial begin
    // basic order: first output one edge after the first write
    row(1,32'hFFFFFFFF,0,0,           0,32'h0,       0,0,0);
    row(0,0,1,32'hEEEEEEEE,           1,32'hFFFFFFFF,0,0,0);
    row(1,32'hDDDDDDDD,0,0,           1,32'hEEEEEEEE,0,0,0);
    row(0,0,1,32'hCCCCCCCC,           1,32'hDDDDDDDD,0,0,0);
    row(0,0,0,0,                      1,32'hCCCCCCCC,0,0,0);
    row(0,0,0,0,                      0,32'hCCCCCCCC,0,0,0);
    // lane 1 arrives two edges early
    row(0,0,1,32'h4,                  0,32'hCCCCCCCC,0,0,0);
    row(0,0,0,0,                      0,32'hCCCCCCCC,0,0,0);
    row(1,32'h3,0,0,                  0,32'hCCCCCCCC,0,0,0);
    row(0,0,0,0,                      1,32'h3,       0,0,0);
    row(0,0,0,0,                      1,32'h4,       0,0,0);
    row(0,0,0,0,                      0,32'h4,       0,0,0);
    // bubbles between pairs
    row(1,32'hAAAAAAAA,0,0,           0,32'h4,       0,0,0);
    row(0,0,1,32'h99999999,           1,32'hAAAAAAAA,0,0,0);
    row(0,0,0,0,                      1,32'h99999999,0,0,0);
    row(0,0,0,0,                      0,32'h99999999,0,0,0);
    row(1,32'h3,0,0,                  0,32'h99999999,0,0,0);
    row(0,0,1,32'h4,                  1,32'h3,       0,0,0);
    row(0,0,0,0,                      1,32'h4,       0,0,0);
    row(0,0,0,0,                      0,32'h4,       0,0,0);
    // fill FIFO 0 while lane 1 stalls, then push and pop it on one edge
    row(1,32'hB0B0B0B0,0,0,           0,32'h4,       0,0,0);
    row(1,32'hB1B1B1B1,0,0,           1,32'hB0B0B0B0,0,0,0);
    row(1,32'hB2B2B2B2,0,0,           0,32'hB0B0B0B0,0,0,0);
    row(1,32'hB3B3B3B3,0,0,           0,32'hB0B0B0B0,0,0,0);
    row(1,32'hB4B4B4B4,0,0,           0,32'hB0B0B0B0,1,0,0);
    row(0,0,1,32'hC0C0C0C0,           0,32'hB0B0B0B0,1,0,0);
    row(0,0,0,0,                      1,32'hC0C0C0C0,1,0,0);
    row(1,32'hB5B5B5B5,0,0,           1,32'hB1B1B1B1,1,0,0);
    row(0,0,1,32'hC1C1C1C1,           0,32'hB1B1B1B1,1,0,0);
    row(0,0,1,32'hC2C2C2C2,           1,32'hC1C1C1C1,1,0,0);
    row(0,0,0,0,                      1,32'hB2B2B2B2,0,0,0);
    row(0,0,0,0,                      1,32'hC2C2C2C2,0,0,0);
    row(0,0,0,0,                      1,32'hB3B3B3B3,0,0,0);
    row(0,0,1,32'hC3C3C3C3,           0,32'hB3B3B3B3,0,0,0);
    row(0,0,1,32'hC4C4C4C4,           1,32'hC3C3C3C3,0,0,0);
    row(0,0,0,0,                      1,32'hB4B4B4B4,0,0,0);
    row(0,0,0,0,                      1,32'hC4C4C4C4,0,0,0);
    row(0,0,0,0,                      1,32'hB5B5B5B5,0,0,0);
    row(0,0,1,32'hD1D1D1D1,           0,32'hB5B5B5B5,0,0,0);
    row(0,0,0,0,                      1,32'hD1D1D1D1,0,0,0);
    row(0,0,0,0,                      0,32'hD1D1D1D1,0,0,0);
    // lane 1 overflow: fifth word dropped
    row(0,0,1,32'h11111111,           0,32'hD1D1D1D1,0,0,0);
    row(0,0,1,32'h22222222,           0,32'hD1D1D1D1,0,0,0);
    row(0,0,1,32'h33333333,           0,32'hD1D1D1D1,0,0,0);
    row(0,0,1,32'h44444444,           0,32'hD1D1D1D1,0,1,0);
    row(0,0,1,32'h55555555,           0,32'hD1D1D1D1,0,1,1);
    row(1,32'h01010101,0,0,           0,32'hD1D1D1D1,0,1,1);
    row(1,32'h02020202,0,0,           1,32'h01010101,0,1,1);
    row(1,32'h03030303,0,0,           1,32'h11111111,0,0,1);
    row(1,32'h04040404,0,0,           1,32'h02020202,0,0,1);
    row(0,0,0,0,                      1,32'h22222222,0,0,1);
    row(0,0,0,0,                      1,32'h03030303,0,0,1);
    row(0,0,0,0,                      1,32'h33333333,0,0,1);
    row(0,0,0,0,                      1,32'h04040404,0,0,1);
    row(0,0,0,0,                      1,32'h44444444,0,0,1);
    row(0,0,0,0,                      0,32'h44444444,0,0,1);
    row(0,0,0,0,                      0,32'h44444444,0,0,1);

    reset = 1'b1;
    valid_0 = 1'b0; valid_1 = 1'b0; lane_0 = '0; lane_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 32'h0);
    check("reset fifo_full_0", {31'd0, fifo_full_0}, 32'd0);
    check("reset fifo_full_1", {31'd0, fifo_full_1}, 32'd0);
`ifdef UNSTRIPE_ERR_EN
    check("reset err_overflow", {31'd0, err_overflow}, 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v0, vecs[i].l0, vecs[i].v1, vecs[i].l1);
      check_out($sformatf("vec%0d", i), vecs[i].evo, vecs[i].edo);
      check($sformatf("vec%0d fifo_full_0", i), {31'd0, fifo_full_0}, {31'd0, vecs[i].ef0});
      check($sformatf("vec%0d fifo_full_1", i), {31'd0, fifo_full_1}, {31'd0, vecs[i].ef1});
`ifdef UNSTRIPE_ERR_EN
      check($sformatf("vec%0d err_overflow", i), {31'd0, err_overflow}, {31'd0, vecs[i].eerr});
`endif
    end
`ifdef UNSTRIPE_ERR_EN
    check("err_lane", {31'd0, err_lane}, 32'd1);
`endif

    // reset mid-stream: 3 of 6 words written, buffered words discarded
    step(1, 32'hA1A1A1A1, 0, 0);
    check_out("mid w0", 1'b0, 32'h44444444);
    step(0, 0, 1, 32'hB2B2B2B2);
    check_out("mid w1", 1'b1, 32'hA1A1A1A1);
    step(1, 32'hC3C3C3C3, 0, 0);
    check_out("mid w2", 1'b1, 32'hB2B2B2B2);
    valid_0 = 1'b0; valid_1 = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_out("async reset", 1'b0, 32'h0);
`ifdef UNSTRIPE_ERR_EN
    check("async reset err_overflow", {31'd0, err_overflow}, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 32'h12345678, 0, 0);
    check_out("post w0", 1'b0, 32'h0);
    step(0, 0, 1, 32'h9ABCDEF0);
    check_out("post w1", 1'b1, 32'h12345678);
    step(0, 0, 0, 0);
    check_out("post w2", 1'b1, 32'h9ABCDEF0);
    step(0, 0, 0, 0);
    check_out("post idle", 1'b0, 32'h9ABCDEF0);
    step(0, 0, 0, 0);
    check_out("post idle2", 1'b0, 32'h9ABCDEF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/byte_unstriping.md
Name: byte_unstriping

Overview:
- Downstream neighbour of the two-lane byte striper.
- Consumes the two 32-bit lane streams (lane 0 carries words 0,2,4,…; lane 1 carries words 1,3,5,…) and re-interleaves them into one ordered 32-bit stream.
- A small per-lane FIFO absorbs inter-lane skew and bubbles.
- Output order is always lane 0, lane 1, lane 0, … from reset.

Parameters:
- DATA_W, 32, word width per lane and output.
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- lane_0  input  DATA_W  lane 0 word.
- valid_0  input  1  lane_0 qualifier; a word is accepted on every rising edge with valid_0=1.
- lane_1  input  DATA_W  lane 1 word.
- valid_1  input  1  lane_1 qualifier.
- data_out  output  DATA_W  merged word, registered.
- valid_out  output  1  data_out qualifier, registered.
- fifo_full_0  output  1  lane 0 FIFO holds FIFO_DEPTH entries (combinational from count).
- fifo_full_1  output  1  lane 1 FIFO holds FIFO_DEPTH entries.

Behaviour:
- Reset (async assert, sync release):
  - data_out=0, valid_out=0.
  - Both FIFOs empty, pointers and counts 0.
  - Lane select sel=0.
  - fifo_full_*=0.
- Write: edge with valid_i=1 pushes lane_i into FIFO i. There is no backpressure to the striper.
- Per-edge emission decision uses FIFO state at the start of the cycle:
  - FIFO[sel] non-empty: data_out<=head of FIFO[sel], valid_out<=1, pop FIFO[sel], sel<=~sel.
  - Otherwise: valid_out<=0, data_out holds its previous value, sel unchanged.
- No bypass: a word pushed at edge k is emitted no earlier than edge k+1. Minimum latency is therefore 1 cycle from the accepting edge to valid_out.
- Lane 1 data never overtakes lane 0 data. With sel=0, a non-empty FIFO 1 waits.
- Simultaneous push and pop on the same FIFO in one cycle: both occur and the count is unchanged. This is legal when the FIFO is full.
- Overflow: push when count==FIFO_DEPTH and no pop that cycle.
  - The incoming word is dropped.
  - FIFO contents, pointers and count are unchanged.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- Steady state: striper input at 1 word/clk gives alternating valid_0/valid_1. Output is then 1 word/clk, gapless after the first word.
- Reset mid-operation: all buffered words are discarded. Next output is the first lane 0 word written after reset deasserts.

Optional Feature:
- Macro: UNSTRIPE_ERR_EN.
- Defined:
  - Adds output err_overflow (1 bit). It is sticky: it goes to 1 on the edge after any overflow on either lane.
  - It is cleared only by reset.
  - Adds output err_lane (1 bit), which records the lane of the first overflow.
- Undefined: both ports are absent and overflow is silent. Data-path behaviour is identical in both builds.

Decomposition:
- Package byte_unstriping_pkg:
  - DATA_W default.
  - FIFO_DEPTH default.
  - Localparam PTR_W=$clog2(FIFO_DEPTH).
  - Lane-select encoding constants LANE0=1'b0, LANE1=1'b1.
- Sub-module lane_fifo, instantiated twice:
  - Inputs: clk, reset, push, din, pop.
  - Outputs: dout (head), empty, full, overflow pulse.
  - Top level holds sel, the output registers and the optional error logic.

Test Plan:
- Reset, then lane_0=FFFFFFFF, lane_1=EEEEEEEE, lane_0=DDDDDDDD, lane_1=CCCCCCCC on consecutive edges (alternating valids) -> data_out FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on 4 consecutive edges, first one edge after the first write; valid_out low otherwise.
- Lane skew: lane_1=00000004 arrives 2 edges before lane_0=00000003 -> output 00000003 then 00000004; valid_out=0 until lane 0 word is buffered.
- Bubbles: pair AAAAAAAA/99999999, 2 idle cycles, pair 00000003/00000004 -> valid_out drops for exactly the idle gap; order preserved; data_out holds 99999999 during the gap.
- Overflow: 5 lane_1 words 11111111..55555555 with no lane 0 data -> fifo_full_1=1 after 4th; 5th dropped. Then 4 lane_0 words -> output alternates L0,11111111,…,L0,44444444. With UNSTRIPE_ERR_EN: err_overflow=1, err_lane=1.
- Full with simultaneous push/pop: FIFO 0 full while draining, push on same edge -> no drop, count stays 4, no error.
- Reset mid-stream after 3 of 6 words written -> valid_out=0 and data_out=0 immediately on reset assertion. After release, new stream 12345678/9ABCDEF0 emerges in order starting with lane 0.
